sw_debounce: RTL and testbench

- Conditions the raw board switch inputs before they reach the memory-mapped switch register in memory_system.
- Each bit is synchronised into the system clock domain, then filtered with a stability counter.
- Outputs: clean levels, one-cycle rise/fall pulses, and sticky per-bit change flags that software clears through a mask strobe.
- Sits between the top-level sw_in pins and memory_system; runs on sys_clk.

---
 rtl/sw_debounce.sv | 117 +++++++++++
 tb/tb_sw_debounce.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : Conditions raw board switch inputs for the memory-mapped switch
//             register. Each bit is brought into the clock domain by a
//             two-flop synchroniser and then filtered by a per-bit stability
//             counter. Produces clean levels, one-cycle rise/fall pulses and
//             sticky per-bit change flags cleared by a software mask strobe.
//
//  Ports    : clk_in       system clock
//             rst_in       synchronous reset, active-high
//             sw_in        raw asynchronous switch levels      [WIDTH]
//             clr_in       per-bit clear strobe for changed_out [WIDTH]
//             sw_out       debounced switch levels             [WIDTH]
//             rise_out     one-cycle pulse on debounced 0->1   [WIDTH]
//             fall_out     one-cycle pulse on debounced 1->0   [WIDTH]
//             changed_out  sticky "transitioned since clear"   [WIDTH]
//
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2000000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] clr_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic [WIDTH-1:0] changed_out
);

    localparam int              CNT_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int              C_LAST_INT = STABLE_CYCLES - 1;
    localparam logic [CNT_W-1:0] C_LAST    = C_LAST_INT[CNT_W-1:0];

    // Synchroniser: nothing may sit between the two stages.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] chg_q;

    // Per-bit update request: the debounced bit flips on this edge.
    logic [WIDTH-1:0] upd_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             upd;

            // The counter only ever runs while s2 disagrees with the
            // debounced level; it clears on the update edge itself, so it
            // can never exceed STABLE_CYCLES-1 and never wraps.
            always_comb begin
                cnt_d = '0;
                upd   = 1'b0;
                if (sync2_q[gi] != sw_q[gi]) begin
                    if (cnt_q == C_LAST) begin
                        upd = 1'b1;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign upd_d[gi] = upd;
        end
    endgenerate

    // An update always moves sw_q to the opposite level, so the direction of
    // the event is given by the level before the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sw_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= '0;
        end else begin
            sw_q   <= sw_q ^ upd_d;
            rise_q <= upd_d & ~sw_q;
            fall_q <= upd_d &  sw_q;
            // A new event takes priority over a clear on the same bit.
            chg_q  <= upd_d | (chg_q & ~clr_in);
        end
    end

    assign sw_out      = sw_q;
    assign rise_out    = rise_q;
    assign fall_out    = fall_q;
    assign changed_out = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_debounce
//  Purpose  : Self-checking bench for sw_debounce (WIDTH=16, STABLE_CYCLES=8).
//             Directed scenarios followed by a randomized phase, all compared
//             against a sliding-window reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

    localparam int W = 16;
    localparam int S = 8;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic [W-1:0] sw_in;
    logic [W-1:0] clr_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise_out;
    logic [W-1:0] fall_out;
    logic [W-1:0] changed_out;

    sw_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) u_dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sw_in       (sw_in),
        .clr_in      (clr_in),
        .sw_out      (sw_out),
        .rise_out    (rise_out),
        .fall_out    (fall_out),
        .changed_out (changed_out)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: synchroniser as a two-deep delay line; the filter is
    // a window test over the history of filter inputs seen at each edge.
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_chg;
    logic [W-1:0] hist[$];
    int           ec       = 0;
    int           last_rst = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] clr, input logic rst);
        logic [W-1:0] upd;
        bit           ok;
        hist.push_back(m_s2);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0;
            m_rise = '0; m_fall = '0; m_chg = '0;
            last_rst = ec;
        end else begin
            upd = '0;
            // Flip a bit when the last S filter inputs, all after the most
            // recent reset edge, disagree with the current debounced level.
            if (ec - S >= last_rst) begin
                for (int i = 0; i < W; i++) begin
                    ok = 1'b1;
                    for (int j = 0; j < S; j++)
                        if (hist[ec-j][i] == m_out[i]) ok = 1'b0;
                    upd[i] = ok;
                end
            end
            m_rise = upd & ~m_out;
            m_fall = upd & m_out;
            m_out  = m_out ^ upd;
            m_chg  = upd | (m_chg & ~clr);
            m_s2   = m_s1;
            m_s1   = sw;
        end
        ec++;
    endtask

    task automatic step(input logic [W-1:0] sw, input logic [W-1:0] clr, input logic rst);
        sw_in  = sw;
        clr_in = clr;
        rst_in = rst;
        @(posedge clk_in);
        model_edge(sw, clr, rst);
        #1;
        chk("model_sw",      sw_out,      m_out);
        chk("model_rise",    rise_out,    m_rise);
        chk("model_fall",    fall_out,    m_fall);
        chk("model_changed", changed_out, m_chg);
    endtask

    initial begin
        int           n;
        int           rises;
        int           rise_at;
        logic         bad;
        logic         chg5;
        logic [W-1:0] cur;

        m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = '0;
        sw_in = '0; clr_in = '0; rst_in = 1'b1;

        // ---- Reset with all switches high --------------------------------
        for (int k = 0; k < 3; k++) begin
            step(16'hFFFF, 16'h0000, 1'b1);
            chk("rst_sw_zero",  sw_out,      16'h0000);
            chk("rst_chg_zero", changed_out, 16'h0000);
        end
        n = 0;
        for (int k = 0; k < 30 && n == 0; k++) begin
            step(16'hFFFF, 16'h0000, 1'b0);
            if (k == 0) chk("post_rst_sw_zero", sw_out, 16'h0000);
            if (sw_out == 16'hFFFF) begin
                n = k + 1;
                chk("rst_rise_all", rise_out,    16'hFFFF);
                chk("rst_chg_all",  changed_out, 16'hFFFF);
            end
        end
        chk("rst_release_latency", 16'(n), 16'd10);
        step(16'hFFFF, 16'hFFFF, 1'b0);
        chk("rise_single_cycle", rise_out, 16'h0000);

        // ---- Return all bits low, clear flags ----------------------------
        for (int k = 0; k < 12; k++) step(16'h0000, 16'h0000, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b0);
        chk("all_low_cleared", changed_out, 16'h0000);

        // ---- Clean step on bit 3 -----------------------------------------
        for (int k = 0; k < 12; k++) begin
            step(16'h0008, 16'h0000, 1'b0);
            chk("step_sw3",   16'(sw_out[3]),   16'(k >= 9));
            chk("step_rise3", 16'(rise_out[3]), 16'(k == 9));
        end
        chk("step_chg3", 16'(changed_out[3]), 16'd1);

        // ---- Bounce on bit 0 ---------------------------------------------
        rises = 0;
        for (int k = 0; k < 12; k++) begin
            step((k / 3) % 2 == 0 ? 16'h0009 : 16'h0008, 16'h0000, 1'b0);
            if (rise_out[0]) rises++;
        end
        rise_at = -1;
        for (int k = 0; k < 14; k++) begin
            step(16'h0009, 16'h0000, 1'b0);
            if (rise_out[0]) begin
                rises++;
                rise_at = k;
            end
        end
        chk("bounce_rise_count", 16'(rises),   16'd1);
        chk("bounce_rise_edge",  16'(rise_at), 16'd9);

        // ---- Glitch on bit 5 ---------------------------------------------
        for (int k = 0; k < 12; k++) step(16'h0029, 16'h0000, 1'b0);
        step(16'h0029, 16'hFFFF, 1'b0);
        chg5 = changed_out[5];
        bad  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(16'h0009, 16'h0000, 1'b0);
            if (!sw_out[5] || fall_out[5] || changed_out[5] != chg5) bad = 1'b1;
        end
        for (int k = 0; k < 12; k++) begin
            step(16'h0029, 16'h0000, 1'b0);
            if (!sw_out[5] || fall_out[5] || changed_out[5] != chg5) bad = 1'b1;
        end
        chk("glitch_rejected", 16'(bad),       16'd0);
        chk("glitch_sw5_high", 16'(sw_out[5]), 16'd1);

        // ---- Clear vs set on bit 2 ---------------------------------------
        for (int k = 0; k < 12; k++) step(16'h002F, 16'h0000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(16'h002B, k == 9 ? 16'h0006 : 16'h0000, 1'b0);
            if (k == 9) begin
                chk("clrset_fall2", 16'(fall_out[2]),    16'd1);
                chk("clrset_chg2",  16'(changed_out[2]), 16'd1);
                chk("clrset_chg1",  16'(changed_out[1]), 16'd0);
            end
        end
        step(16'h002B, 16'h0004, 1'b0);
        chk("clr_chg2", 16'(changed_out[2]), 16'd0);

        // ---- Reset mid-count on bit 7 ------------------------------------
        for (int k = 0; k < 5; k++) step(16'h00AB, 16'h0000, 1'b0);
        step(16'h00AB, 16'h0000, 1'b1);
        chk("midrst_sw7", 16'(sw_out[7]), 16'd0);
        n = 0;
        for (int k = 0; k < 30 && n == 0; k++) begin
            step(16'h00AB, 16'h0000, 1'b0);
            if (sw_out[7]) n = k + 1;
        end
        chk("midrst_latency", 16'(n), 16'd10);

        // ---- Randomized phase --------------------------------------------
        cur = 16'h00AB;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 15) == 0) cur[i] = ~cur[i];
            step(cur, 16'($urandom & $urandom & $urandom), $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
